// File: rtl/intersection_phase_scheduler_if.sv
// Signal-head bus between the phase scheduler and the intersection (sensors in, lamps out).
// EMERGENCY_PREEMPT_EN adds the preempt request and its target phase.
interface intersection_phase_scheduler_if #(
  parameter int N_PHASES = 4
);
  logic [N_PHASES-1:0] req;
  logic [N_PHASES-1:0] green;
  logic [N_PHASES-1:0] yellow;
  logic [N_PHASES-1:0] red;
  logic [2:0]          cur_phase;
  logic                phase_start;
`ifdef EMERGENCY_PREEMPT_EN
  logic                preempt;
  logic [2:0]          preempt_phase;

  modport master (output req, preempt, preempt_phase,
                  input  green, yellow, red, cur_phase, phase_start);
  modport slave  (input  req, preempt, preempt_phase,
                  output green, yellow, red, cur_phase, phase_start);
`else
  modport master (output req,
                  input  green, yellow, red, cur_phase, phase_start);
  modport slave  (input  req,
                  output green, yellow, red, cur_phase, phase_start);
`endif
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Round-robin green-phase scheduler with GREEN -> YELLOW -> ALL-RED clearance and min/max green.
// Optional emergency preemption is compiled in with EMERGENCY_PREEMPT_EN.
module intersection_phase_scheduler #(
  parameter int N_PHASES  = 4,
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2
) (
  input logic                          Clk,
  input logic                          reset,
  intersection_phase_scheduler_if.slave bus
);

  localparam int T_TOP = (MAX_GREEN > YELLOW_T)
                         ? ((MAX_GREEN > ALLRED_T) ? MAX_GREEN : ALLRED_T)
                         : ((YELLOW_T > ALLRED_T) ? YELLOW_T : ALLRED_T);
  localparam int TW = $clog2(T_TOP + 1);

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [TW-1:0]       timer, timer_n;
  logic [N_PHASES-1:0] pending, pending_n;
  logic [2:0]          cur, cur_n;
  logic [2:0]          nxt, nxt_n;
  logic [N_PHASES-1:0] green_r, yellow_r, red_r;
  logic                phase_start_r;

  logic [N_PHASES-1:0] cur_mask;
  logic                other, home, req_cur, min_done, max_done;
  logic                go_yellow;
  logic [2:0]          nxt_eff;
  logic [N_PHASES-1:0] green_n, yellow_n;

  function automatic logic [N_PHASES-1:0] onehot(input logic [2:0] idx);
    logic [N_PHASES-1:0] m;
    m = '0;
    for (int k = 0; k < N_PHASES; k++) m[k] = (int'(idx) == k);
    return m;
  endfunction

  // First pending phase after c in cyclic order, falling back to the home phase.
  function automatic logic [2:0] next_pending(input logic [N_PHASES-1:0] pend,
                                              input logic [2:0] c);
    logic [2:0] r;
    int         j;
    r = '0;
    for (int i = N_PHASES - 1; i >= 1; i--) begin
      j = (int'(c) + i) % N_PHASES;
      if (pend[j]) r = 3'(j);
    end
    return r;
  endfunction

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
    return (t == '1) ? t : t + TW'(1);
  endfunction

  assign cur_mask = onehot(cur);
  assign other    = |(pending & ~cur_mask);
  assign home     = (cur != 3'd0) && !other;
  assign req_cur  = |(bus.req & cur_mask);
  assign min_done = (timer >= TW'(MIN_GREEN - 1));
  assign max_done = (timer >= TW'(MAX_GREEN - 1));

  always_comb begin
    state_n   = state;
    timer_n   = sat_inc(timer);
    pending_n = pending | bus.req;
    cur_n     = cur;
    nxt_n     = nxt;
    go_yellow = min_done && (other || home) && (!req_cur || max_done);
    nxt_eff   = nxt;
`ifdef EMERGENCY_PREEMPT_EN
    if (bus.preempt) begin
      go_yellow = (bus.preempt_phase != cur);
      nxt_eff   = bus.preempt_phase;
    end
`endif
    case (state)
      S_GREEN: begin
        pending_n = pending_n & ~cur_mask;
        if (go_yellow) begin
          state_n = S_YELLOW;
          timer_n = '0;
          nxt_n   = next_pending(pending, cur);
`ifdef EMERGENCY_PREEMPT_EN
          if (bus.preempt) nxt_n = bus.preempt_phase;
`endif
        end
      end
      S_YELLOW: begin
        nxt_n = nxt_eff;
        if (timer >= TW'(YELLOW_T - 1)) begin
          state_n = S_ALLRED;
          timer_n = '0;
        end
      end
      S_ALLRED: begin
        nxt_n = nxt_eff;
        if (timer >= TW'(ALLRED_T - 1)) begin
          state_n   = S_GREEN;
          timer_n   = '0;
          cur_n     = nxt_eff;
          pending_n = pending_n & ~onehot(nxt_eff);
        end
      end
      default: begin
        state_n = S_ALLRED;
        timer_n = '0;
        nxt_n   = '0;
      end
    endcase
    green_n  = (state_n == S_GREEN)  ? onehot(cur_n) : '0;
    yellow_n = (state_n == S_YELLOW) ? onehot(cur_n) : '0;
  end

  // Lamps are registered from the next-state values so they switch on the transition edge.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state         <= S_GREEN;
      timer         <= '0;
      pending       <= '0;
      cur           <= '0;
      nxt           <= '0;
      green_r       <= onehot(3'd0);
      yellow_r      <= '0;
      red_r         <= ~onehot(3'd0);
      phase_start_r <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      pending       <= pending_n;
      cur           <= cur_n;
      nxt           <= nxt_n;
      green_r       <= green_n;
      yellow_r      <= yellow_n;
      red_r         <= ~(green_n | yellow_n);
      phase_start_r <= (state == S_ALLRED) && (state_n == S_GREEN);
    end
  end

  assign bus.green       = green_r;
  assign bus.yellow      = yellow_r;
  assign bus.red         = red_r;
  assign bus.cur_phase   = cur;
  assign bus.phase_start = phase_start_r;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: table of request scenarios with expected phase timelines,
// plus hand-written reset-during-yellow and (with EMERGENCY_PREEMPT_EN) preemption sequences.
module tb_intersection_phase_scheduler;

  localparam int Y  = 3;
  localparam int AR = 2;
  localparam int NV = 9;

  logic Clk;
  logic reset;

  intersection_phase_scheduler_if #(.N_PHASES(4)) bus ();

  intersection_phase_scheduler #(
    .N_PHASES(4), .MIN_GREEN(8), .MAX_GREEN(20), .YELLOW_T(3), .ALLRED_T(2)
  ) dut (
    .Clk  (Clk),
    .reset(reset),
    .bus  (bus)
  );

  // Scenario: up to two request pulses, one held request window, and the expected
  // sequence of green phases with their green lengths (last entry rests forever).
  typedef struct packed {
    logic [3:0]       pm0;
    int               pc0;
    logic [3:0]       pm1;
    int               pc1;
    logic [3:0]       hm;
    int               hs;
    int               he;
    int               len;
    int               nseg;
    logic [4:0][2:0]  ph;
    logic [4:0][7:0]  gl;
  } vec_t;

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] y;
    logic [3:0] r;
    logic [2:0] cur;
    logic       ps;
  } exp_t;

  vec_t vecs [NV];
  exp_t sbq [$];
  int   checks = 0;
  int   errors = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] oh(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return one << k;
  endfunction

  function automatic vec_t mk(input logic [3:0] pm0, input int pc0,
                              input logic [3:0] pm1, input int pc1,
                              input logic [3:0] hm, input int hs, input int he,
                              input int len, input int nseg,
                              input int p0, input int g0, input int p1, input int g1,
                              input int p2, input int g2, input int p3, input int g3,
                              input int p4);
    vec_t v;
    v = '0;
    v.pm0 = pm0; v.pc0 = pc0; v.pm1 = pm1; v.pc1 = pc1;
    v.hm = hm; v.hs = hs; v.he = he; v.len = len; v.nseg = nseg;
    v.ph[0] = 3'(p0); v.ph[1] = 3'(p1); v.ph[2] = 3'(p2); v.ph[3] = 3'(p3); v.ph[4] = 3'(p4);
    v.gl[0] = 8'(g0); v.gl[1] = 8'(g1); v.gl[2] = 8'(g2); v.gl[3] = 8'(g3);
    return v;
  endfunction

  function automatic logic [3:0] req_at(input vec_t v, input int p);
    logic [3:0] r;
    r = '0;
    if (p == v.pc0) r = r | v.pm0;
    if (p == v.pc1) r = r | v.pm1;
    if (p >= v.hs && p <= v.he) r = r | v.hm;
    return r;
  endfunction

  // Expected lamps for output period p (period 0 follows the last reset edge).
  function automatic exp_t exp_at(input vec_t v, input int p);
    exp_t e;
    int   t;
    bit   done;
    e = '0; t = 0; done = 1'b0;
    for (int s = 0; s < 5; s++) begin
      if (!done && s < v.nseg) begin
        int ph;
        int gl;
        ph = int'(v.ph[s]);
        gl = int'(v.gl[s]);
        if (s == v.nseg - 1 || p < t + gl) begin
          e.g = oh(ph); e.cur = 3'(ph); e.ps = (s > 0 && p == t); done = 1'b1;
        end else if (p < t + gl + Y) begin
          e.y = oh(ph); e.cur = 3'(ph); done = 1'b1;
        end else if (p < t + gl + Y + AR) begin
          e.cur = 3'(ph); done = 1'b1;
        end else begin
          t = t + gl + Y + AR;
        end
      end
    end
    e.r = ~(e.g | e.y);
    return e;
  endfunction

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
`ifdef EMERGENCY_PREEMPT_EN
    bus.preempt       = 1'b0;
    bus.preempt_phase = 3'd0;
`endif
    repeat (3) @(posedge Clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic step(input logic [3:0] r, input logic rs, input exp_t e,
                      input int tag, input int p);
    exp_t a;
    exp_t x;
    bus.req = r;
    reset   = rs;
    sbq.push_back(e);
    @(negedge Clk);
    x = sbq.pop_front();
    a.g = bus.green; a.y = bus.yellow; a.r = bus.red;
    a.cur = bus.cur_phase; a.ps = bus.phase_start;
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL seq%0d p%0d: got g=%b y=%b r=%b cur=%0d ps=%b, want g=%b y=%b r=%b cur=%0d ps=%b",
               tag, p, a.g, a.y, a.r, a.cur, a.ps, x.g, x.y, x.r, x.cur, x.ps);
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    vec_t v5;
    reset   = 1'b1;
    bus.req = '0;

    vecs[0] = mk(4'b0000, -1, 4'b0000, -1, 4'b0000, -1, -1, 50, 1, 0,0, 0,0, 0,0, 0,0, 0);
    vecs[1] = mk(4'b0100,  3, 4'b0000, -1, 4'b0000, -1, -1, 40, 3, 0,8, 2,8, 0,0, 0,0, 0);
    vecs[2] = mk(4'b1010,  3, 4'b0000, -1, 4'b0000, -1, -1, 50, 4, 0,8, 1,8, 3,8, 0,0, 0);
    vecs[3] = mk(4'b0100, 15, 4'b0000, -1, 4'b0010,  3, 32, 60, 4, 0,8, 1,20, 2,8, 0,0, 0);
    vecs[4] = mk(4'b1110,  3, 4'b0000, -1, 4'b0000, -1, -1, 60, 5, 0,8, 1,8, 2,8, 3,8, 0);
    vecs[5] = mk(4'b0100,  3, 4'b0010, 15, 4'b0000, -1, -1, 45, 4, 0,8, 2,8, 1,8, 0,0, 0);
    vecs[6] = mk(4'b0100,  3, 4'b0100, 22, 4'b0000, -1, -1, 60, 5, 0,8, 2,8, 0,8, 2,8, 0);
    vecs[7] = mk(4'b1000, 20, 4'b0000, -1, 4'b0000, -1, -1, 50, 3, 0,22, 3,8, 0,0, 0,0, 0);
    vecs[8] = mk(4'b0001,  5, 4'b0000, -1, 4'b0001, 20, 30, 40, 1, 0,0, 0,0, 0,0, 0,0, 0);

    for (int i = 0; i < NV; i++) begin
      do_reset();
      for (int p = 0; p < vecs[i].len; p++)
        step(req_at(vecs[i], p), 1'b0, exp_at(vecs[i], p), i, p);
    end

    // Reset on the second yellow cycle while phases 2 and 3 are pending: home phase rests afterwards.
    v5 = mk(4'b1100, 3, 4'b0000, -1, 4'b0000, -1, -1, 10, 3, 0,8, 2,8, 0,0, 0,0, 0);
    do_reset();
    for (int p = 0; p < 9; p++) step(req_at(v5, p), 1'b0, exp_at(v5, p), 20, p);
    step(4'b0000, 1'b1, exp_at(v5, 9), 20, 9);
    for (int p = 10; p < 41; p++) step(4'b0000, 1'b0, exp_at(vecs[0], 0), 20, p);

`ifdef EMERGENCY_PREEMPT_EN
    begin
      vec_t vp;
      vp = mk(4'b0000, -1, 4'b0000, -1, 4'b0000, -1, -1, 60, 3, 0,3, 3,31, 0,0, 0,0, 0);
      do_reset();
      for (int p = 0; p < vp.len; p++) begin
        bus.preempt       = (p >= 2 && p <= 37);
        bus.preempt_phase = 3'd3;
        step(4'b0000, 1'b0, exp_at(vp, p), 30, p);
      end
      bus.preempt = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
